// File: rtl/gtfwizard_0_init_pkg.sv
// gtfwizard_0_init_pkg: state encodings and sizing/limit helpers for the multi-channel GTF init controller
package gtfwizard_0_init_pkg;
  typedef enum logic [2:0] {T_START, T_WAIT, T_RST, T_DONE, T_FAIL} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_WAIT, R_RST, R_MON, R_FAIL} rx_state_e;
  function automatic int cnt_w(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction
  function automatic logic limit_hit(input int unsigned cnt, input int unsigned lim);
    return lim != 0 && cnt >= lim;
  endfunction
endpackage

// File: rtl/gtfwizard_0_init_rx_ch.sv
// gtfwizard_0_init_rx_ch: one RX bring-up supervisor (FSM, timer, loss filter, retry counter)
// clk_i/rst_i clock and sync reset; rx_en_i from TX supervisor; rx_init_done_i/rx_data_good_i status;
// reset_rx_o pulse, init_done_o in MONITOR, fail_o retry limit hit, retry_ctr_o saturating retries
module gtfwizard_0_init_rx_ch
  import gtfwizard_0_init_pkg::*;
#(
  parameter int P_RX_TIMER_CYC  = 26000000,
  parameter int P_RST_PULSE_CYC = 4,
  parameter int P_LOSS_FILT_CYC = 8,
  parameter int P_MAX_RETRY     = 0,
  parameter int P_RETRY_W       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_en_i,
  input  logic                 rx_init_done_i,
  input  logic                 rx_data_good_i,
  output logic                 reset_rx_o,
  output logic                 init_done_o,
  output logic                 fail_o,
  output logic [P_RETRY_W-1:0] retry_ctr_o
);
  localparam int TW = cnt_w(P_RX_TIMER_CYC > P_RST_PULSE_CYC ? P_RX_TIMER_CYC : P_RST_PULSE_CYC);
  localparam int LW = cnt_w(P_LOSS_FILT_CYC);
  rx_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] loss_q, loss_d;
  logic [P_RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic reset_rx_q, reset_rx_d, init_done_q, init_done_d, fail_q, fail_d;
  logic good, wait_end, rst_end, loss_hit, eval_bad;
  assign good      = rx_init_done_i & rx_data_good_i;
  assign retry_inc = &retry_q ? retry_q : retry_q + 1'b1;
  assign wait_end  = timer_q == TW'(P_RX_TIMER_CYC);
  assign rst_end   = timer_q == TW'(P_RST_PULSE_CYC - 1);
  // the bad cycle that brings the filter count up to its limit declares the loss
  assign loss_hit  = !good && loss_q == LW'(P_LOSS_FILT_CYC - 1);
  assign eval_bad  = rx_en_i && ((state_q == R_WAIT && wait_end && !good) || (state_q == R_MON && loss_hit));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= R_IDLE;
      timer_q     <= '0;
      loss_q      <= '0;
      retry_q     <= '0;
      reset_rx_q  <= 1'b0;
      init_done_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      reset_rx_q  <= reset_rx_d;
      init_done_q <= init_done_d;
      fail_q      <= fail_d;
    end
  end
  always_comb begin
    state_d = state_q == R_FAIL ? R_FAIL :
              !rx_en_i ? R_IDLE :
              state_q == R_IDLE ? R_WAIT :
              eval_bad ? (limit_hit(32'(retry_inc), P_MAX_RETRY) ? R_FAIL : R_RST) :
              (state_q == R_WAIT && wait_end) ? R_MON :
              (state_q == R_RST && rst_end) ? R_WAIT : state_q;
    timer_d = (state_d != state_q || !(state_q inside {R_WAIT, R_RST})) ? '0 : timer_q + 1'b1;
    loss_d  = (state_q == R_MON && state_d == R_MON && !good) ? loss_q + 1'b1 : '0;
    retry_d = eval_bad ? retry_inc : retry_q;
  end
  always_comb begin
    reset_rx_d  = state_d == R_RST;
    init_done_d = state_d == R_MON;
    fail_d      = state_d == R_FAIL;
  end
  assign reset_rx_o  = reset_rx_q;
  assign init_done_o = init_done_q;
  assign fail_o      = fail_q;
  assign retry_ctr_o = retry_q;
endmodule

// File: rtl/gtfwizard_0_example_init_multi.sv
// gtfwizard_0_example_init_multi: shared TX bring-up supervisor plus P_NUM_CH RX supervisors for GTF channels
// clk_freerun_in/reset_all_in clock and sync reset; *_init_done_in/rx_data_good_in channel status;
// reset_all_out master reset pulse, reset_rx_out per-channel pulses, init/fail flags and retry counts
module gtfwizard_0_example_init_multi
  import gtfwizard_0_init_pkg::*;
#(
  parameter int P_NUM_CH        = 4,
  parameter int P_TX_TIMER_CYC  = 6000000,
  parameter int P_RX_TIMER_CYC  = 26000000,
  parameter int P_RST_PULSE_CYC = 4,
  parameter int P_LOSS_FILT_CYC = 8,
  parameter int P_MAX_RETRY     = 0,
  parameter int P_RETRY_W       = 4
) (
  input  logic                          clk_freerun_in,
  input  logic                          reset_all_in,
  input  logic [P_NUM_CH-1:0]           tx_init_done_in,
  input  logic [P_NUM_CH-1:0]           rx_init_done_in,
  input  logic [P_NUM_CH-1:0]           rx_data_good_in,
  output logic                          reset_all_out,
  output logic [P_NUM_CH-1:0]           reset_rx_out,
  output logic [P_NUM_CH-1:0]           init_done_out,
  output logic                          all_init_done_out,
  output logic [P_NUM_CH-1:0]           fail_out,
  output logic                          tx_fail_out,
  output logic [P_RETRY_W-1:0]          tx_retry_ctr_out,
  output logic [P_NUM_CH*P_RETRY_W-1:0] retry_ctr_out
);
  localparam int TW = cnt_w(P_TX_TIMER_CYC > P_RST_PULSE_CYC ? P_TX_TIMER_CYC : P_RST_PULSE_CYC);
  tx_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [P_RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic reset_all_q, reset_all_d, tx_fail_q, tx_fail_d;
  logic tx_all, timeout, rx_en;
  assign tx_all    = &tx_init_done_in;
  assign retry_inc = &retry_q ? retry_q : retry_q + 1'b1;
  // all-done wins over a timeout landing in the same cycle
  assign timeout   = state_q == T_WAIT && !tx_all && timer_q == TW'(P_TX_TIMER_CYC);
  assign rx_en     = state_q == T_DONE;
  always_ff @(posedge clk_freerun_in) begin
    if (reset_all_in) begin
      state_q     <= T_START;
      timer_q     <= '0;
      retry_q     <= '0;
      reset_all_q <= 1'b0;
      tx_fail_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      reset_all_q <= reset_all_d;
      tx_fail_q   <= tx_fail_d;
    end
  end
  always_comb begin
    state_d = state_q == T_START ? T_WAIT :
              state_q == T_WAIT ? (tx_all ? T_DONE : timeout ? (limit_hit(32'(retry_inc), P_MAX_RETRY) ? T_FAIL : T_RST) : T_WAIT) :
              state_q == T_RST ? (timer_q == TW'(P_RST_PULSE_CYC - 1) ? T_START : T_RST) :
              state_q == T_DONE ? (tx_all ? T_DONE : T_START) : T_FAIL;
    timer_d = (state_d != state_q || !(state_q inside {T_WAIT, T_RST})) ? '0 : timer_q + 1'b1;
    retry_d = timeout ? retry_inc : retry_q;
  end
  always_comb begin
    reset_all_d = state_d == T_RST;
    tx_fail_d   = state_d == T_FAIL;
  end
  for (genvar i = 0; i < P_NUM_CH; i++) begin : g_ch
    gtfwizard_0_init_rx_ch #(
      .P_RX_TIMER_CYC (P_RX_TIMER_CYC),
      .P_RST_PULSE_CYC(P_RST_PULSE_CYC),
      .P_LOSS_FILT_CYC(P_LOSS_FILT_CYC),
      .P_MAX_RETRY    (P_MAX_RETRY),
      .P_RETRY_W      (P_RETRY_W)
    ) u_ch (
      .clk_i         (clk_freerun_in),
      .rst_i         (reset_all_in),
      .rx_en_i       (rx_en),
      .rx_init_done_i(rx_init_done_in[i]),
      .rx_data_good_i(rx_data_good_in[i]),
      .reset_rx_o    (reset_rx_out[i]),
      .init_done_o   (init_done_out[i]),
      .fail_o        (fail_out[i]),
      .retry_ctr_o   (retry_ctr_out[i*P_RETRY_W +: P_RETRY_W])
    );
  end
  assign reset_all_out     = reset_all_q;
  assign tx_fail_out       = tx_fail_q;
  assign tx_retry_ctr_out  = retry_q;
  assign all_init_done_out = &init_done_out;
endmodule
